// File: rtl/full_adder_pkg.sv
// ============================================================================
// Module : full_adder_pkg
// Brief  : Shared width limits and bit-level helpers for the adder slice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package full_adder_pkg;

    localparam int FA_MIN_WIDTH = 1;
    localparam int FA_MAX_WIDTH = 64;

    // Carry generate of a full-adder bit: majority of the three inputs.
    function automatic logic fa_majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : full_adder_pkg

`default_nettype wire

// File: rtl/full_adder_fa_cell.sv
// ============================================================================
// Module : fa_cell
// Brief  : One-bit full adder, the ripple element of full_adder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ c;
    assign cout = fa_majority(a, b, c);

endmodule : fa_cell

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module : full_adder
// Brief  : WIDTH-bit ripple-carry adder with optional registered outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic             ci,
    output logic [WIDTH-1:0] r,
    output logic             co,
    output logic             ovf,
    output logic             o_valid
);

    localparam int c_width_ok = ((WIDTH >= FA_MIN_WIDTH) && (WIDTH <= FA_MAX_WIDTH)) ? 1 : 0;

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    assign w_carry[0] = ci;

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        fa_cell u_cell (
            .a    (i1[k]),
            .b    (i2[k]),
            .c    (w_carry[k]),
            .s    (w_sum[k]),
            .cout (w_carry[k+1])
        );
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign w_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];

    if (REG_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] r_d,   r_q;
        logic             co_d,  co_q;
        logic             ovf_d, ovf_q;
        logic             valid_d, valid_q;

        always_comb begin
            r_d     = r_q;
            co_d    = co_q;
            ovf_d   = ovf_q;
            valid_d = i_valid;
            if (i_valid) begin
                r_d   = w_sum;
                co_d  = w_carry[WIDTH];
                ovf_d = w_ovf;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q     <= '0;
                co_q    <= 1'b0;
                ovf_q   <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                r_q     <= r_d;
                co_q    <= co_d;
                ovf_q   <= ovf_d;
                valid_q <= valid_d;
            end
        end

        assign r       = r_q;
        assign co      = co_q;
        assign ovf     = ovf_q;
        assign o_valid = valid_q;
    end else begin : g_comb
        // Clock and reset are intentionally left unused in this configuration.
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk ^ rst_n ^ c_width_ok[0];

        assign r       = w_sum;
        assign co      = w_carry[WIDTH];
        assign ovf     = w_ovf;
        assign o_valid = i_valid;
    end

endmodule : full_adder

`default_nettype wire

// File: tb/tb_full_adder.sv
// ============================================================================
// Module : tb_full_adder
// Brief  : Directed self-checking bench for full_adder in four configurations.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_miscmp  = 0;

    // WIDTH=1 combinational
    logic       a1_v, a1_a, a1_b, a1_c;
    logic       a1_r, a1_co, a1_ovf, a1_ov;
    // WIDTH=8 combinational
    logic       a8_v, a8_c;
    logic [7:0] a8_a, a8_b, a8_r;
    logic       a8_co, a8_ovf, a8_ov;
    // WIDTH=8 registered
    logic       q8_v, q8_c;
    logic [7:0] q8_a, q8_b, q8_r;
    logic       q8_co, q8_ovf, q8_ov;
    // WIDTH=16 combinational
    logic        a16_v, a16_c;
    logic [15:0] a16_a, a16_b, a16_r;
    logic        a16_co, a16_ovf, a16_ov;

    full_adder #(.WIDTH(1), .REG_OUT(0)) u_w1 (
        .clk(clk), .rst_n(rst_n), .i_valid(a1_v), .i1(a1_a), .i2(a1_b), .ci(a1_c),
        .r(a1_r), .co(a1_co), .ovf(a1_ovf), .o_valid(a1_ov));

    full_adder #(.WIDTH(8), .REG_OUT(0)) u_w8 (
        .clk(clk), .rst_n(rst_n), .i_valid(a8_v), .i1(a8_a), .i2(a8_b), .ci(a8_c),
        .r(a8_r), .co(a8_co), .ovf(a8_ovf), .o_valid(a8_ov));

    full_adder #(.WIDTH(8), .REG_OUT(1)) u_w8r (
        .clk(clk), .rst_n(rst_n), .i_valid(q8_v), .i1(q8_a), .i2(q8_b), .ci(q8_c),
        .r(q8_r), .co(q8_co), .ovf(q8_ovf), .o_valid(q8_ov));

    full_adder #(.WIDTH(16), .REG_OUT(0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .i_valid(a16_v), .i1(a16_a), .i2(a16_b), .ci(a16_c),
        .r(a16_r), .co(a16_co), .ovf(a16_ovf), .o_valid(a16_ov));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_q8(input string tag, input logic [7:0] er, input logic eco,
                          input logic eovf, input logic eov);
        chk({tag, ".r"},   {24'd0, q8_r}, {24'd0, er});
        chk({tag, ".co"},  {31'd0, q8_co},  {31'd0, eco});
        chk({tag, ".ovf"}, {31'd0, q8_ovf}, {31'd0, eovf});
        chk({tag, ".ov"},  {31'd0, q8_ov},  {31'd0, eov});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  exp_r1, exp_co1;
        logic [7:0]  t_a [3], t_b [3], t_r [3];
        logic        t_c [3], t_co [3], t_ovf [3];
        logic [16:0] m_sum;
        logic        m_ovf;

        rst_n = 1'b0;
        a1_v = 1'b1; a1_a = 1'b0; a1_b = 1'b0; a1_c = 1'b0;
        a8_v = 1'b1; a8_a = '0;   a8_b = '0;   a8_c = 1'b0;
        q8_v = 1'b0; q8_a = 8'h5A; q8_b = 8'hA5; q8_c = 1'b1;
        a16_v = 1'b1; a16_a = '0; a16_b = '0;  a16_c = 1'b0;

        // Asynchronous reset is visible before any clock edge.
        #1;
        chk_q8("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Exhaustive 1-bit table, index = {a,b,c}.
        exp_r1  = 8'b1001_0110;
        exp_co1 = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            {a1_a, a1_b, a1_c} = i[2:0];
            #10;
            chk($sformatf("w1[%0d].r", i),   {31'd0, a1_r},   {31'd0, exp_r1[i]});
            chk($sformatf("w1[%0d].co", i),  {31'd0, a1_co},  {31'd0, exp_co1[i]});
            chk($sformatf("w1[%0d].ovf", i), {31'd0, a1_ovf}, {31'd0, exp_co1[i] ^ a1_c});
            chk($sformatf("w1[%0d].ov", i),  {31'd0, a1_ov},  32'd1);
        end
        a1_v = 1'b0;
        #10;
        chk("w1.ov_low", {31'd0, a1_ov}, 32'd0);

        // 8-bit boundary vectors.
        t_a[0] = 8'hFF; t_b[0] = 8'h01; t_c[0] = 1'b0; t_r[0] = 8'h00; t_co[0] = 1'b1; t_ovf[0] = 1'b0;
        t_a[1] = 8'h7F; t_b[1] = 8'h01; t_c[1] = 1'b0; t_r[1] = 8'h80; t_co[1] = 1'b0; t_ovf[1] = 1'b1;
        t_a[2] = 8'h80; t_b[2] = 8'h80; t_c[2] = 1'b1; t_r[2] = 8'h01; t_co[2] = 1'b1; t_ovf[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a8_a = t_a[i]; a8_b = t_b[i]; a8_c = t_c[i];
            #10;
            chk($sformatf("w8[%0d].r", i),   {24'd0, a8_r},   {24'd0, t_r[i]});
            chk($sformatf("w8[%0d].co", i),  {31'd0, a8_co},  {31'd0, t_co[i]});
            chk($sformatf("w8[%0d].ovf", i), {31'd0, a8_ovf}, {31'd0, t_ovf[i]});
        end

        // 16-bit random against an arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            a16_a = 16'($urandom);
            a16_b = 16'($urandom);
            a16_c = 1'($urandom_range(0, 1));
            #2;
            m_sum = {1'b0, a16_a} + {1'b0, a16_b} + {16'd0, a16_c};
            m_ovf = (a16_a[15] == a16_b[15]) && (m_sum[15] != a16_a[15]);
            chk($sformatf("w16[%0d].r", i),   {16'd0, a16_r},   {16'd0, m_sum[15:0]});
            chk($sformatf("w16[%0d].co", i),  {31'd0, a16_co},  {31'd0, m_sum[16]});
            chk($sformatf("w16[%0d].ovf", i), {31'd0, a16_ovf}, {31'd0, m_ovf});
        end

        // Registered stage: release reset away from the active edge.
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_q8("pre", 8'h00, 1'b0, 1'b0, 1'b0);

        q8_v = 1'b1; q8_a = 8'h10; q8_b = 8'h20; q8_c = 1'b0;
        tick();
        chk_q8("s0", 8'h30, 1'b0, 1'b0, 1'b1);
        q8_a = 8'h01; q8_b = 8'h02; q8_c = 1'b1;
        tick();
        chk_q8("s1", 8'h04, 1'b0, 1'b0, 1'b1);
        q8_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q8_a = 8'(8'h33 + 8'(i * 17)); q8_b = 8'hF0; q8_c = i[0];
            tick();
            chk_q8($sformatf("hold%0d", i), 8'h04, 1'b0, 1'b0, 1'b0);
        end

        // Hold again with carry and overflow set.
        q8_v = 1'b1; q8_a = 8'h80; q8_b = 8'h80; q8_c = 1'b1;
        tick();
        chk_q8("s2", 8'h01, 1'b1, 1'b1, 1'b1);
        q8_v = 1'b0; q8_a = 8'h00; q8_b = 8'h00; q8_c = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_q8($sformatf("hold_c%0d", i), 8'h01, 1'b1, 1'b1, 1'b0);
            q8_a = 8'h7F;
        end

        // Mid-stream reset between edges with a result pending.
        q8_v = 1'b1; q8_a = 8'h80; q8_b = 8'hFF; q8_c = 1'b0;
        tick();
        chk_q8("pend", 8'h7F, 1'b1, 1'b1, 1'b1);
        q8_a = 8'h0F; q8_b = 8'h01;
        #2;
        rst_n = 1'b0;
        #1;
        chk_q8("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        q8_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_q8("post", 8'h00, 1'b0, 1'b0, 1'b0);
        q8_v = 1'b1; q8_a = 8'h05; q8_b = 8'h06; q8_c = 1'b0;
        tick();
        chk_q8("first", 8'h0B, 1'b0, 1'b0, 1'b1);
        q8_v = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule : tb_full_adder

`default_nettype wire

// File: doc/full_adder.md
# full_adder

Parameterisable binary adder: adds operands `i1` and `i2` plus carry-in `ci`, producing sum `r` and carry-out `co`. It is the leaf arithmetic primitive used by wider datapaths. With default parameters it is a purely combinational 1-bit full adder. An optional output register stage can be enabled; that stage uses the single clock and reset.

## Interface
Parameters:
- `WIDTH`, default 1: operand and sum width in bits (≥1).
- `REG_OUT`, default 0: 0 = combinational outputs; 1 = outputs registered one clock later.

Ports:
- `clk`  input  1: the single clock; used only when `REG_OUT=1`.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `i_valid`  input  1: marks the operands valid; tie high if unused.
- `i1`  input  WIDTH: addend A, unsigned or two's complement.
- `i2`  input  WIDTH: addend B.
- `ci`  input  1: carry-in.
- `r`  output  WIDTH: sum bits.
- `co`  output  1: carry-out of the MSB.
- `ovf`  output  1: signed overflow, equal to carry into MSB XOR carry out of MSB.
- `o_valid`  output  1: `r`, `co` and `ovf` are valid.

## Operation
- {co, r} = i1 + i2 + ci, computed at WIDTH+1 bits; no truncation beyond that.
- Per bit k:
  - r[k] = a^b^c
  - c[k+1] = (a&b) | (a&c) | (b&c)
  - c[0] = ci; co = c[WIDTH].
- `ovf` = c[WIDTH-1] ^ c[WIDTH]. For WIDTH=1 this is ci ^ co.
- Carry chain is ripple; no lookahead is required.
- REG_OUT=0:
  - Outputs follow inputs combinationally.
  - o_valid = i_valid.
  - clk and rst_n have no effect.
- REG_OUT=1:
  - r, co and ovf are captured on every rising clk edge when i_valid=1 and hold otherwise.
  - o_valid is a registered copy of i_valid.
- All inputs X-free is a precondition; no X-propagation handling is required.

## Timing
- REG_OUT=0: zero-cycle latency; outputs settle within one propagation delay. Benches sample ≥1 time unit after input change.
- REG_OUT=1: latency is 1 cycle; throughput is one add per cycle; there is no backpressure.
- Reset when REG_OUT=1: while rst_n=0, r=0, co=0, ovf=0, o_valid=0, applied immediately without waiting for clk.
- Reset asserted mid-stream discards the in-flight result. The first valid output after deassertion comes from the first i_valid=1 edge after deassertion.
- Simultaneous rst_n deassertion and a clk edge: that edge does not capture; deassertion is synchronised by the parent.
- Wrap-around: all-ones + 1 + ci=0 gives r=0, co=1.

## Structure
- Sub-module `fa_cell`: 1-bit full adder with inputs a, b, c and outputs s, cout. Instantiated WIDTH times in a generate loop to form the ripple chain.
- Top level wraps the chain plus an optional output register, selected by a generate on REG_OUT.
- No shared package is needed. If a common arithmetic package exists, WIDTH limits may be placed there; there are no typedefs.

## Test plan
- WIDTH=1, REG_OUT=0, exhaustive 8 combinations with 10-time-unit spacing. Every combination must hold:
  - 000→r0 co0
  - 001→r1 co0
  - 010→r1 co0
  - 011→r0 co1
  - 100→r1 co0
  - 101→r0 co1
  - 110→r0 co1
  - 111→r1 co1
- WIDTH=8, REG_OUT=0:
  - 0xFF+0x01+0 → r=0x00, co=1, ovf=0
  - 0x7F+0x01+0 → r=0x80, co=0, ovf=1
  - 0x80+0x80+1 → r=0x01, co=1, ovf=1
- WIDTH=8, REG_OUT=1: stream 0x10+0x20+0 then 0x01+0x02+1 on consecutive cycles. Expect r=0x30 one cycle later, then r=0x04; o_valid high for exactly those two cycles.
- REG_OUT=1, i_valid=0 for 3 cycles with changing operands → r, co and ovf hold their last value; o_valid=0.
- REG_OUT=1, assert rst_n=0 between clock edges while a result is pending → outputs are 0 immediately. After release, the next i_valid=1 result appears after 1 cycle.
- Random WIDTH=16, REG_OUT=0: 1000 vectors compared against a behavioural {co,r} = i1+i2+ci model.
